// File: rtl/rx_command_decoder_if.sv
// Byte stream from the UART receiver, memory write port and core action request,
// bundled between the command decoder and its neighbours.
interface rx_command_decoder_if;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       core_busy;
    logic       wr_en_a;
    logic       wr_en_b;
    logic [7:0] wr_data;
    logic [9:0] wr_addr;
    logic [5:0] action;
    logic       err;

    modport master (
        input  rx_data,
        input  rx_ready,
        input  core_busy,
        output wr_en_a,
        output wr_en_b,
        output wr_data,
        output wr_addr,
        output action,
        output err
    );

    modport slave (
        output rx_data,
        output rx_ready,
        output core_busy,
        input  wr_en_a,
        input  wr_en_b,
        input  wr_data,
        input  wr_addr,
        input  action,
        input  err
    );
endinterface

// File: rtl/rx_command_decoder.sv
// Decodes UART command bytes into operand loads for memories A/B or one-cycle
// one-hot action requests for the processing core.
module rx_command_decoder #(
    parameter int unsigned N_ELEMENTS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input logic                  clk,
    input logic                  rst,
    rx_command_decoder_if.master bus
);
    localparam int unsigned IDX_W = (N_ELEMENTS > 1) ? $clog2(N_ELEMENTS) : 1;
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ELEMENTS - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_PEND   = 3'd3;
    localparam logic [2:0] S_ISSUE  = 3'd4;

    logic [2:0]       r_state;
    logic [IDX_W-1:0] r_index;
    logic [TMR_W-1:0] r_timer;
    logic [5:0]       r_code;
    logic             r_wr_en_a;
    logic             r_wr_en_b;
    logic [7:0]       r_wr_data;
    logic [9:0]       r_wr_addr;
    logic [5:0]       r_action;
    logic             r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            r_timer   <= '0;
            r_code    <= '0;
            r_wr_en_a <= 1'b0;
            r_wr_en_b <= 1'b0;
            r_wr_data <= '0;
            r_wr_addr <= '0;
            r_action  <= '0;
            r_err     <= 1'b0;
        end else begin
            r_wr_en_a <= 1'b0;
            r_wr_en_b <= 1'b0;
            r_action  <= '0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.rx_ready) begin
                        r_index <= '0;
                        r_timer <= '0;
                        case (bus.rx_data)
                            8'h01:   r_state <= S_LOAD_A;
                            8'h02:   r_state <= S_LOAD_B;
                            8'h03:   begin r_code <= 6'b000001; r_state <= S_PEND; end
                            8'h04:   begin r_code <= 6'b000010; r_state <= S_PEND; end
                            8'h05:   begin r_code <= 6'b000100; r_state <= S_PEND; end
                            8'h06:   begin r_code <= 6'b001000; r_state <= S_PEND; end
                            default: r_err <= 1'b1;
                        endcase
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    // An accepted byte wins over a timeout expiring on the same edge.
                    if (bus.rx_ready) begin
                        r_wr_en_a <= (r_state == S_LOAD_A);
                        r_wr_en_b <= (r_state == S_LOAD_B);
                        r_wr_data <= bus.rx_data;
                        r_wr_addr <= {{(10 - IDX_W){1'b0}}, r_index};
                        r_timer   <= '0;
                        if (r_index == IDX_LAST) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_index <= r_index + 1'b1;
                        end
                    end else if (r_timer == TMR_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_PEND: begin
                    r_err <= bus.rx_ready;
                    if (!bus.core_busy) begin
                        r_action <= r_code;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_err   <= bus.rx_ready;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_en_a = r_wr_en_a;
    assign bus.wr_en_b = r_wr_en_b;
    assign bus.wr_data = r_wr_data;
    assign bus.wr_addr = r_wr_addr;
    assign bus.action  = r_action;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_rx_command_decoder.sv
// Randomised and directed stimulus for rx_command_decoder, checked cycle by cycle
// against a transaction-level reference model.
module tb_rx_command_decoder;
    localparam int N_EL = 4;
    localparam int TMO  = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    rx_command_decoder_if bus ();

    rx_command_decoder #(
        .N_ELEMENTS     (N_EL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: what the decoder is doing, in protocol terms
    int         load_sel;    // 0 none, 1 filling A, 2 filling B
    int         load_idx;    // elements written so far in this load
    int         quiet;       // edges without a byte since last accepted byte/command
    logic [5:0] want;        // requested action still waiting for the core
    bit         issue_edge;  // action is being presented this cycle
    logic       exp_wa, exp_wb, exp_err;
    logic [5:0] exp_act;
    logic [7:0] exp_data;
    logic [9:0] exp_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        load_sel = 0; load_idx = 0; quiet = 0; want = '0; issue_edge = 0;
        exp_wa = 0; exp_wb = 0; exp_err = 0; exp_act = '0; exp_data = '0; exp_addr = '0;
    endtask

    task automatic model_edge(input logic rdy, input logic [7:0] data, input logic busy);
        exp_wa = 0; exp_wb = 0; exp_err = 0; exp_act = '0;
        if (issue_edge) begin
            issue_edge = 0;
            exp_err = rdy;
        end else if (want != 0) begin
            exp_err = rdy;
            if (!busy) begin
                exp_act = want;
                want = '0;
                issue_edge = 1;
            end
        end else if (load_sel != 0) begin
            if (rdy) begin
                exp_wa   = (load_sel == 1);
                exp_wb   = (load_sel == 2);
                exp_data = data;
                exp_addr = 10'(load_idx);
                load_idx++;
                quiet = 0;
                if (load_idx == N_EL) load_sel = 0;
            end else begin
                quiet++;
                if (quiet == TMO) begin
                    exp_err = 1;
                    load_sel = 0;
                end
            end
        end else if (rdy) begin
            if (data == 8'h01 || data == 8'h02) begin
                load_sel = int'(data);
                load_idx = 0;
                quiet = 0;
            end else if (data >= 8'h03 && data <= 8'h06) begin
                want = 6'b000001 << (data - 8'h03);
            end else begin
                exp_err = 1;
            end
        end
    endtask

    task automatic check_outputs();
        check("wr_en_a", 32'(bus.wr_en_a), 32'(exp_wa));
        check("wr_en_b", 32'(bus.wr_en_b), 32'(exp_wb));
        check("action", 32'(bus.action), 32'(exp_act));
        check("err", 32'(bus.err), 32'(exp_err));
        if (exp_wa || exp_wb) begin
            check("wr_data", 32'(bus.wr_data), 32'(exp_data));
            check("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en_a"}, 32'(bus.wr_en_a), 32'd0);
        check({tag, "_wr_en_b"}, 32'(bus.wr_en_b), 32'd0);
        check({tag, "_wr_data"}, 32'(bus.wr_data), 32'd0);
        check({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        check({tag, "_action"}, 32'(bus.action), 32'd0);
        check({tag, "_err"}, 32'(bus.err), 32'd0);
    endtask

    task automatic step(input logic rdy, input logic [7:0] data, input logic busy);
        @(negedge clk);
        check_outputs();
        bus.rx_ready  = rdy;
        bus.rx_data   = data;
        bus.core_busy = busy;
        model_edge(rdy, data, busy);
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0);
    endtask

    initial begin
        int rate;
        bit busy;
        bus.rx_ready = 0; bus.rx_data = '0; bus.core_busy = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst = 0;

        // Load A
        send(8'h01); send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        idle(2);

        // Load B then send-B action
        send(8'h02);
        for (int i = 0; i < N_EL; i++) send(8'($urandom));
        send(8'h04);
        idle(4);

        // Sum request held off by a busy core, with a stray byte during the wait
        send(8'h05);
        for (int i = 0; i < 50; i++) step(i == 20, 8'h99, 1'b1);
        idle(4);

        // Load timeout, then a fresh B load from address 0
        send(8'h01); send(8'hAA);
        idle(TMO + 5);
        send(8'h02);
        for (int i = 0; i < N_EL; i++) send(8'h5A + 8'(i));
        idle(2);

        // Unknown command, then average request
        send(8'h7F);
        idle(2);
        send(8'h06);
        idle(4);

        // Byte arriving on the very edge the timeout would expire is accepted
        send(8'h01);
        idle(TMO - 1);
        send(8'hC3);
        idle(TMO + 2);

        // Asynchronous reset mid-load
        send(8'h01); send(8'h11); send(8'h22);
        step(1'b0, 8'h00, 1'b0);
        #1 rst = 1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 0;
        send(8'h55);
        idle(3);

        // Random traffic with varying byte density and core busy periods
        rate = 70;
        busy = 0;
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] d;
            if (i % 100 == 0) begin
                case ($urandom_range(0, 2))
                    0: rate = 70;
                    1: rate = 30;
                    default: rate = 3;
                endcase
            end
            if ($urandom_range(0, 99) < 10) busy = ~busy;
            d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 6)) : 8'($urandom);
            step($urandom_range(0, 99) < rate, d, busy);
        end
        idle(TMO + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
